// File: rtl/uart_pkg.sv
// Shared state encoding, register offsets and STATUS layout for the MMIO UART transmitter.
// Defining UART_TX_PARITY_EN adds an even-parity bit and the PARITY state to every frame.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } txState_t;

    localparam logic [9:0] TXDATA_OFS = 10'd0;
    localparam logic [9:0] STATUS_OFS = 10'd1;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_EMPTY  = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_CNT_LO = 4;
    localparam int STAT_CNT_HI = 8;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif

endpackage

// File: rtl/uart_fifo.sv
// Transmit byte FIFO; a push into a full FIFO is accepted only when a pop frees a slot at the same edge.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW:0]      count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wrPtr_d = doPush ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + PW'(1) : rdPtr_q;
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, byte FIFO, baud counter and frame FSM.
// Build with UART_TX_PARITY_EN defined to append an even-parity bit after the data bits.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int         CLK_DIV    = 434,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [9:0] BASE_ADDR  = 10'h3F0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [9:0]  ADDRESS,
    input  logic [31:0] DATA_IN,
    input  logic        WRITE,
    input  logic        READ,
    output logic [31:0] DATA_OUT,
    output logic        TX,
    output logic        IRQ
);

    localparam logic [9:0]  TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
    localparam logic [9:0]  STATUS_ADDR = BASE_ADDR + STATUS_OFS;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

    txState_t    state_q, state_d;
    logic [15:0] baudCnt_q, baudCnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif
    logic        overflow_q, overflow_d;
    logic [31:0] dataOut_q, dataOut_d;

    logic                          fifoPush;
    logic                          fifoPop;
    logic                          fifoFull;
    logic                          fifoEmpty;
    logic [$clog2(FIFO_DEPTH):0]   fifoCount;
    logic [7:0]                    fifoData;

    logic        bitDone;
    logic        loadFrame;
    logic        busy;
    logic        statusRead;
    logic        txdataRead;
    logic        dropped;
    logic [31:0] statusWord;
    logic        unusedDataBits;

    assign unusedDataBits = ^DATA_IN[31:8];

    assign fifoPush   = WRITE && (ADDRESS == TXDATA_ADDR);
    assign statusRead = READ && (ADDRESS == STATUS_ADDR);
    assign txdataRead = READ && (ADDRESS == TXDATA_ADDR);
    assign dropped    = fifoPush && fifoFull && !fifoPop;
    assign bitDone    = (baudCnt_q == 16'd0);

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) uFifo (
        .clk_i   (CLK),
        .reset_i (RESET),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .wdata_i (DATA_IN[7:0]),
        .rdata_o (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
            overflow_q <= 1'b0;
            dataOut_q  <= '0;
        end else begin
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
            overflow_q <= overflow_d;
            dataOut_q  <= dataOut_d;
        end
    end

    // Every bit, including the stop bit, ends when the down-counter reaches zero; a frame
    // that ends with bytes still queued reloads straight into START for gap-free output.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = bitDone ? BAUD_RELOAD : baudCnt_q - 16'd1;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        loadFrame = 1'b0;
        fifoPop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baudCnt_d = baudCnt_q;
                loadFrame = !fifoEmpty;
            end
            ST_START: begin
                if (bitDone) begin
                    state_d  = ST_DATA;
                    bitIdx_d = '0;
                end
            end
            ST_DATA: begin
                if (bitDone) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bitIdx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bitDone) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bitDone) begin
                    state_d   = ST_IDLE;
                    loadFrame = !fifoEmpty;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (loadFrame) begin
            fifoPop   = 1'b1;
            state_d   = ST_START;
            baudCnt_d = BAUD_RELOAD;
            bitIdx_d  = '0;
            shift_d   = fifoData;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifoData;
`endif
        end
    end

    always_comb begin
        TX   = 1'b1;
        busy = 1'b1;
        case (state_q)
            ST_IDLE:   busy = 1'b0;
            ST_START:  TX   = 1'b0;
            ST_DATA:   TX   = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: TX   = parity_q;
`endif
            default:   TX   = 1'b1;
        endcase
    end

    assign IRQ = fifoEmpty && !busy;

    always_comb begin
        statusWord                           = '0;
        statusWord[STAT_BUSY]                = busy;
        statusWord[STAT_FULL]                = fifoFull;
        statusWord[STAT_EMPTY]               = fifoEmpty;
        statusWord[STAT_OVF]                 = overflow_q;
        statusWord[STAT_CNT_HI:STAT_CNT_LO]  = 5'(fifoCount);
    end

    // A drop at the same edge as a STATUS read re-arms the flag so that event is not lost.
    always_comb begin
        overflow_d = overflow_q;
        if (dropped) begin
            overflow_d = 1'b1;
        end else if (statusRead) begin
            overflow_d = 1'b0;
        end

        dataOut_d = dataOut_q;
        if (statusRead) begin
            dataOut_d = statusWord;
        end else if (txdataRead) begin
            dataOut_d = '0;
        end
    end

    assign DATA_OUT = dataOut_q;

endmodule
